// File: rtl/fb_read_streamer_pkg.sv
// Shared constants and types for the framebuffer read streamer: SDRAM command
// encodings, read burst length and the streamer FSM state type.
package fb_read_streamer_pkg;

    localparam logic [1:0] CMD_IDLE  = 2'b00;
    localparam logic [1:0] CMD_WRITE = 2'b01;
    localparam logic [1:0] CMD_READ  = 2'b10;

    localparam int READ_BURST_LENGTH = 4;

    typedef enum logic [1:0] {
        ST_WAIT_INIT = 2'd0,
        ST_IDLE      = 2'd1,
        ST_READ      = 2'd2
    } state_e;

endpackage

// File: rtl/fb_read_streamer_if.sv
// Bus bundle between the streamer, the shared SDRAM controller command port
// and the LCD pixel consumer. The master side is the streamer itself.
interface fb_read_streamer_if #(
    parameter int ADDR_W = 22
);
    logic [1:0]        o_Command;
    logic [ADDR_W-1:0] o_Data_Address;
    logic              i_Data_Read_Valid;
    logic [31:0]       i_Data_Read;
    logic [31:0]       o_Pixel_Data;
    logic              o_Pixel_Valid;
    logic              i_Pixel_Ready;

    modport master (
        output o_Command, o_Data_Address, o_Pixel_Data, o_Pixel_Valid,
        input  i_Data_Read_Valid, i_Data_Read, i_Pixel_Ready
    );

    modport slave (
        input  o_Command, o_Data_Address, o_Pixel_Data, o_Pixel_Valid,
        output i_Data_Read_Valid, i_Data_Read, i_Pixel_Ready
    );
endinterface

// File: rtl/fb_read_streamer_sync_fifo.sv
// First-word-fall-through synchronous FIFO with flush and occupancy count.
// The head word reads as zero while the FIFO is empty.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    input  logic [WIDTH-1:0]           wdata_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             full, do_push, do_pop;

    assign full    = (cnt_q == DEPTH_C);
    assign empty_o = (cnt_q == '0);
    assign do_push = push_i && !full;
    assign do_pop  = pop_i && !empty_o;
    assign count_o = cnt_q;
    assign rdata_o = empty_o ? '0 : mem[rd_q];

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (flush_i) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (do_push) wr_d = wr_q + 1'b1;
            if (do_pop)  rd_d = rd_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt_d = cnt_q + 1'b1;
                2'b01:   cnt_d = cnt_q - 1'b1;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage carries no reset; validity is tracked entirely by the pointers.
    always_ff @(posedge clk) begin
        if (do_push && !flush_i) mem[wr_q] <= wdata_i;
    end

    pushWhenFull: assert property (@(posedge clk) disable iff (rst) !(push_i && full));

endmodule

// File: rtl/fb_read_streamer.sv
// Sweeps the framebuffer with SDRAM read bursts and streams the returned words
// to the LCD pixel path through a FWFT FIFO, with frame resync and underflow flag.
module fb_read_streamer
    import fb_read_streamer_pkg::*;
#(
    parameter int FRAME_WORDS = 96000,
    parameter int FIFO_DEPTH  = 16,
    parameter int ADDR_W      = 22
) (
    input  logic                i_Clk,
    input  logic                i_Reset,
    input  logic                i_SDRAM_Initialized,
    input  logic                i_Frame_Start,
    fb_read_streamer_if.master  bus,
    output logic                o_Underflow
);
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int BCNT_W = (READ_BURST_LENGTH > 1) ? $clog2(READ_BURST_LENGTH) : 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(FRAME_WORDS - 1);
    localparam logic [CNT_W-1:0]  DEPTH_C     = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]  BURST_SLOTS = CNT_W'(READ_BURST_LENGTH);
    localparam logic [BCNT_W-1:0] BCNT_LAST   = BCNT_W'(READ_BURST_LENGTH - 1);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [BCNT_W-1:0]   bcnt_q, bcnt_d;
    logic                resync_q, resync_d;
    logic                underflow_q, underflow_d;

    logic [CNT_W-1:0]    fifo_count;
    logic [CNT_W-1:0]    free_slots;
    logic                fifo_empty;
    logic                fifo_push, fifo_pop, fifo_flush;
    logic                pixel_valid;

    assign free_slots = DEPTH_C - fifo_count;

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            state_q     <= ST_WAIT_INIT;
            addr_q      <= '0;
            bcnt_q      <= '0;
            resync_q    <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            bcnt_q      <= bcnt_d;
            resync_q    <= resync_d;
            underflow_q <= underflow_d;
        end
    end

    // A burst already on the controller is never aborted: a frame start during
    // READ only marks the rest of it as stale, and IDLE does the flush.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        bcnt_d      = bcnt_q;
        resync_d    = resync_q;
        underflow_d = underflow_q |
                      (bus.i_Pixel_Ready && fifo_empty &&
                       (state_q != ST_WAIT_INIT) && !resync_q);
        case (state_q)
            ST_WAIT_INIT: begin
                if (i_SDRAM_Initialized) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (fifo_flush) begin
                    addr_d   = '0;
                    resync_d = 1'b0;
                end else if (free_slots >= BURST_SLOTS) begin
                    state_d = ST_READ;
                    bcnt_d  = BCNT_LAST;
                end
            end
            ST_READ: begin
                if (i_Frame_Start) resync_d = 1'b1;
                if (bus.i_Data_Read_Valid) begin
                    addr_d = (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;
                    if (bcnt_q == '0) state_d = ST_IDLE;
                    else              bcnt_d  = bcnt_q - 1'b1;
                end
            end
            default: state_d = ST_WAIT_INIT;
        endcase
    end

    always_comb begin
        bus.o_Command      = (state_q == ST_READ) ? CMD_READ : CMD_IDLE;
        bus.o_Data_Address = addr_q;
        fifo_flush         = (state_q == ST_IDLE) && (resync_q || i_Frame_Start);
        fifo_push          = (state_q == ST_READ) && bus.i_Data_Read_Valid && !resync_q;
        pixel_valid        = !fifo_empty && !resync_q;
        fifo_pop           = pixel_valid && bus.i_Pixel_Ready;
        bus.o_Pixel_Valid  = pixel_valid;
        o_Underflow        = underflow_q;
    end

    sync_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (i_Clk),
        .rst     (i_Reset),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .flush_i (fifo_flush),
        .wdata_i (bus.i_Data_Read),
        .rdata_o (bus.o_Pixel_Data),
        .count_o (fifo_count),
        .empty_o (fifo_empty)
    );

endmodule

// File: tb/tb_fb_read_streamer.sv
// Directed bench for fb_read_streamer with a small frame (8 words) so address
// wrap, backpressure, resync and reset can all be exercised quickly.
module tb_fb_read_streamer;
    import fb_read_streamer_pkg::*;

    localparam int FRAME_WORDS = 8;
    localparam int FIFO_DEPTH  = 16;
    localparam int ADDR_W      = 22;
    localparam int BL          = READ_BURST_LENGTH;

    logic i_Clk = 1'b0;
    logic i_Reset;
    logic sdramInit;
    logic frameStart;
    logic underflow;

    int checks   = 0;
    int failures = 0;
    logic [31:0]       expQ[$];
    logic [ADDR_W-1:0] expAddr;

    fb_read_streamer_if #(.ADDR_W(ADDR_W)) busIf ();

    fb_read_streamer #(
        .FRAME_WORDS (FRAME_WORDS),
        .FIFO_DEPTH  (FIFO_DEPTH),
        .ADDR_W      (ADDR_W)
    ) dut (
        .i_Clk               (i_Clk),
        .i_Reset             (i_Reset),
        .i_SDRAM_Initialized (sdramInit),
        .i_Frame_Start       (frameStart),
        .bus                 (busIf),
        .o_Underflow         (underflow)
    );

    always #5 i_Clk = ~i_Clk;

    // Compares one observed value against the bench's expectation.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic waitForRead(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (busIf.o_Command == CMD_READ) begin
                seen = 1'b1;
                break;
            end
            @(negedge i_Clk);
        end
    endtask

    // Acts as the SDRAM controller returning one word for the current address.
    task automatic applyStimulus(input bit expectPush);
        logic [31:0] w;
        w = {4{expAddr[7:0]}};
        checkOutput("cmd_read", 32'(busIf.o_Command), 32'(CMD_READ));
        checkOutput("rd_addr", 32'(busIf.o_Data_Address), 32'(expAddr));
        busIf.i_Data_Read_Valid = 1'b1;
        busIf.i_Data_Read       = w;
        @(negedge i_Clk);
        busIf.i_Data_Read_Valid = 1'b0;
        busIf.i_Data_Read       = '0;
        if (expectPush) expQ.push_back(w);
        expAddr = (expAddr == ADDR_W'(FRAME_WORDS - 1)) ? '0 : expAddr + 1'b1;
    endtask

    task automatic serveBurst();
        bit seen;
        waitForRead(20, seen);
        checkOutput("burst_start", 32'(seen), 32'd1);
        if (seen) begin
            for (int i = 0; i < BL; i++) applyStimulus(1'b1);
            checkOutput("cmd_idle_after_burst", 32'(busIf.o_Command), 32'(CMD_IDLE));
        end
    endtask

    task automatic popWord();
        logic [31:0] exp;
        exp = (expQ.size() > 0) ? expQ.pop_front() : 32'hDEAD_BEEF;
        checkOutput("pix_valid", 32'(busIf.o_Pixel_Valid), 32'd1);
        checkOutput("pix_data", busIf.o_Pixel_Data, exp);
        busIf.i_Pixel_Ready = 1'b1;
        @(negedge i_Clk);
        busIf.i_Pixel_Ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit seen;
        int badCmd;
        int bursts;
        int popCount;

        i_Reset    = 1'b1;
        sdramInit  = 1'b0;
        frameStart = 1'b0;
        busIf.i_Data_Read_Valid = 1'b0;
        busIf.i_Data_Read       = '0;
        busIf.i_Pixel_Ready     = 1'b0;
        expAddr = '0;

        repeat (2) @(negedge i_Clk);
        checkOutput("rst_cmd", 32'(busIf.o_Command), 32'(CMD_IDLE));
        checkOutput("rst_addr", 32'(busIf.o_Data_Address), 32'd0);
        checkOutput("rst_valid", 32'(busIf.o_Pixel_Valid), 32'd0);
        checkOutput("rst_data", busIf.o_Pixel_Data, 32'd0);
        checkOutput("rst_underflow", 32'(underflow), 32'd0);
        i_Reset = 1'b0;

        // Init gate: no reads while the SDRAM is not initialised.
        badCmd = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge i_Clk);
            if (busIf.o_Command != CMD_IDLE) badCmd++;
        end
        checkOutput("init_gate", 32'(badCmd), 32'd0);
        sdramInit = 1'b1;
        repeat (2) @(negedge i_Clk);
        checkOutput("init_read", 32'(busIf.o_Command), 32'(CMD_READ));
        checkOutput("init_addr", 32'(busIf.o_Data_Address), 32'd0);

        // First burst, addresses 0..3, then drained in order.
        serveBurst();
        checkOutput("burst_end_addr", 32'(busIf.o_Data_Address), 32'd4);
        for (int i = 0; i < BL; i++) popWord();
        checkOutput("burst_drained_valid", 32'(busIf.o_Pixel_Valid), 32'd0);

        // Backpressure plus frame wrap: bursts until the FIFO is full.
        bursts = 0;
        for (int b = 0; b < 8; b++) begin
            waitForRead(10, seen);
            if (!seen) break;
            for (int i = 0; i < BL; i++) applyStimulus(1'b1);
            bursts++;
            if (bursts == 1)
                checkOutput("wrap_addr", 32'(busIf.o_Data_Address), 32'd0);
        end
        checkOutput("bp_bursts", 32'(bursts), 32'(FIFO_DEPTH / BL));
        checkOutput("bp_cmd_idle", 32'(busIf.o_Command), 32'(CMD_IDLE));
        popCount = expQ.size();
        checkOutput("bp_queue", 32'(popCount), 32'(FIFO_DEPTH));
        for (int i = 0; i < popCount; i++) popWord();
        checkOutput("bp_underflow", 32'(underflow), 32'd0);

        // Frame start after the second word of a burst.
        waitForRead(20, seen);
        checkOutput("rs_burst_start", 32'(seen), 32'd1);
        applyStimulus(1'b1);
        applyStimulus(1'b1);
        checkOutput("rs_valid_before", 32'(busIf.o_Pixel_Valid), 32'd1);
        frameStart = 1'b1;
        @(negedge i_Clk);
        frameStart = 1'b0;
        checkOutput("rs_valid_pending", 32'(busIf.o_Pixel_Valid), 32'd0);
        applyStimulus(1'b0);
        applyStimulus(1'b0);
        expQ.delete();
        checkOutput("rs_cmd_idle", 32'(busIf.o_Command), 32'(CMD_IDLE));
        checkOutput("rs_valid_idle", 32'(busIf.o_Pixel_Valid), 32'd0);
        @(negedge i_Clk);
        checkOutput("rs_flush_addr", 32'(busIf.o_Data_Address), 32'd0);
        checkOutput("rs_flush_cmd", 32'(busIf.o_Command), 32'(CMD_IDLE));
        checkOutput("rs_flush_valid", 32'(busIf.o_Pixel_Valid), 32'd0);
        expAddr = '0;

        // Fill to 15 entries, then push and pop on the same edge.
        serveBurst();
        serveBurst();
        serveBurst();
        waitForRead(20, seen);
        checkOutput("f1_burst_start", 32'(seen), 32'd1);
        for (int i = 0; i < BL - 1; i++) applyStimulus(1'b1);
        checkOutput("f1_head", busIf.o_Pixel_Data, expQ[0]);
        busIf.i_Pixel_Ready = 1'b1;
        applyStimulus(1'b1);
        busIf.i_Pixel_Ready = 1'b0;
        void'(expQ.pop_front());
        checkOutput("f1_cmd_idle", 32'(busIf.o_Command), 32'(CMD_IDLE));
        waitForRead(10, seen);
        checkOutput("f1_no_read", 32'(seen), 32'd0);
        popCount = expQ.size();
        checkOutput("f1_queue", 32'(popCount), 32'(FIFO_DEPTH - 1));
        for (int i = 0; i < popCount; i++) popWord();
        checkOutput("f1_underflow", 32'(underflow), 32'd0);
        checkOutput("f1_drained_valid", 32'(busIf.o_Pixel_Valid), 32'd0);

        // Asynchronous reset in the middle of a burst.
        waitForRead(20, seen);
        checkOutput("mr_burst_start", 32'(seen), 32'd1);
        applyStimulus(1'b1);
        applyStimulus(1'b1);
        checkOutput("mr_valid_before", 32'(busIf.o_Pixel_Valid), 32'd1);
        #2 i_Reset = 1'b1;
        #1;
        checkOutput("mr_cmd", 32'(busIf.o_Command), 32'(CMD_IDLE));
        checkOutput("mr_addr", 32'(busIf.o_Data_Address), 32'd0);
        checkOutput("mr_valid", 32'(busIf.o_Pixel_Valid), 32'd0);
        checkOutput("mr_data", busIf.o_Pixel_Data, 32'd0);
        expQ.delete();
        @(negedge i_Clk);
        i_Reset = 1'b0;
        busIf.i_Pixel_Ready = 1'b1;

        // Underflow ignores WAIT_INIT, then sets and stays set.
        @(negedge i_Clk);
        checkOutput("uf_wait_init", 32'(underflow), 32'd0);
        @(negedge i_Clk);
        checkOutput("uf_set", 32'(underflow), 32'd1);
        busIf.i_Pixel_Ready = 1'b0;
        repeat (2) @(negedge i_Clk);
        checkOutput("uf_sticky", 32'(underflow), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
